// File: rtl/dma_wb_fifo_slave_pkg.sv
// dma_wb_fifo_slave shared types: bus cycle types, FSM states and
// the per-beat decode bundle used by the slave and its FIFOs.
package dma_wb_fifo_slave_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  localparam int LVL_W = 9;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BURST,
    S_RESP
  } state_t;

  typedef struct packed {
    logic ack;
    logic err;
    logic retry;
    logic eod;
    logic push;
    logic pop;
  } beat_t;

  function automatic logic addr_hit(
    input logic [31:0] a,
    input logic [15:0] base
  );
    return (a[31:16] == base) && (a[2:0] == 3'b000);
  endfunction

endpackage

// File: rtl/dma_wb_fifo_slave_fifo.sv
// Synchronous FIFO with occupancy output; push when full and
// pop when empty are dropped.
module dma_wb_fifo_slave_fifo
  import dma_wb_fifo_slave_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int W     = 64
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             push,
  input  logic             pop,
  input  logic [W-1:0]     wdata,
  output logic [W-1:0]     rdata,
  output logic [LVL_W-1:0] level,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (level == LVL_W'(DEPTH));
  assign empty   = (level == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LVL_W'(do_push) - LVL_W'(do_pop);
    end
  end

  // storage carries no reset; pointers alone define what is valid
  always_ff @(posedge clk) begin
    if (rstn && do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/dma_wb_fifo_slave.sv
// Wishbone-style 64-bit slave bridging bus beats to TX/RX FIFOs.
// Define DMA_WB_FIFO_SLAVE_EOD_EN to generate eod on the last RX word.
module dma_wb_fifo_slave
  import dma_wb_fifo_slave_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] BASE_ADDR  = 16'h0000
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cyc,
  input  logic        stb,
  input  logic        lock,
  input  logic        we,
  input  logic [2:0]  cti,
  input  logic [7:0]  sel,
  input  logic [31:0] addr,
  input  logic [63:0] wdat,
  output logic [63:0] rdat,
  output logic        ack,
  output logic        err,
  output logic        retry,
  output logic        eod,
  output logic [63:0] tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [63:0] rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic [8:0]  tx_level,
  output logic [8:0]  rx_level
);

  state_t      state;
  state_t      state_nx;
  beat_t       beat;
  logic        accept;
  logic        bad;
  logic        w_err;
  logic        w_retry;
  logic        w_ok;
  logic        r_retry;
  logic        r_ok;
  logic        tx_full;
  logic        tx_empty;
  logic        rx_full;
  logic        rx_empty;
  logic        eod_d;
  logic        tx_push;
  logic        rx_pop;
  logic [63:0] rx_head;
  logic        unused_lock;

  assign unused_lock = lock;
  assign tx_valid    = !tx_empty;
  assign rx_ready    = !rx_full;
  assign tx_push     = accept && beat.push;
  assign rx_pop      = accept && beat.pop;

`ifdef DMA_WB_FIFO_SLAVE_EOD_EN
  assign eod_d = (rx_level == LVL_W'(1));
`else
  assign eod_d = 1'b0;
`endif

  always_comb begin
    bad     = !addr_hit(addr, BASE_ADDR);
    w_err   = !bad && we && (sel != 8'hFF);
    w_retry = !bad && we && (sel == 8'hFF) && tx_full;
    w_ok    = !bad && we && (sel == 8'hFF) && !tx_full;
    r_retry = !bad && !we && rx_empty;
    r_ok    = !bad && !we && !rx_empty;
  end

  always_comb begin
    beat = '0;
    unique case (1'b1)
      bad, w_err:       beat.err = 1'b1;
      w_retry, r_retry: beat.retry = 1'b1;
      w_ok: begin
        beat.ack  = 1'b1;
        beat.push = 1'b1;
      end
      r_ok: begin
        beat.ack = 1'b1;
        beat.pop = 1'b1;
        beat.eod = eod_d;
      end
      default: beat = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    accept   = 1'b0;
    unique case (state)
      S_IDLE, S_BURST: begin
        accept = cyc && stb;
        if (state == S_BURST && !cyc) begin
          state_nx = S_IDLE;
        end else if (accept) begin
          // a failed beat always ends the burst
          if (beat.err || beat.retry) begin
            state_nx = S_RESP;
          end else begin
            case (cti)
              CTI_INCR:             state_nx = S_BURST;
              CTI_CLASSIC, CTI_EOB: state_nx = S_RESP;
              default:              state_nx = S_RESP;
            endcase
          end
        end
      end
      S_RESP:  state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ack   <= 1'b0;
      err   <= 1'b0;
      retry <= 1'b0;
      eod   <= 1'b0;
      rdat  <= '0;
    end else begin
      ack   <= accept && beat.ack;
      err   <= accept && beat.err;
      retry <= accept && beat.retry;
      eod   <= accept && beat.eod;
      rdat  <= rx_pop ? rx_head : '0;
    end
  end

  dma_wb_fifo_slave_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_tx (
    .clk   (clk),
    .rstn  (rstn),
    .push  (tx_push),
    .pop   (tx_ready),
    .wdata (wdat),
    .rdata (tx_data),
    .level (tx_level),
    .full  (tx_full),
    .empty (tx_empty)
  );

  dma_wb_fifo_slave_fifo #(
    .DEPTH (FIFO_DEPTH),
    .W     (64)
  ) u_rx (
    .clk   (clk),
    .rstn  (rstn),
    .push  (rx_valid),
    .pop   (rx_pop),
    .wdata (rx_data),
    .rdata (rx_head),
    .level (rx_level),
    .full  (rx_full),
    .empty (rx_empty)
  );

endmodule

// File: doc/dma_wb_fifo_slave.md
DMA_WB_FIFO_SLAVE -- requirements
Module: dma_wb_fifo_slave

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
  FIFO_DEPTH, 16, entries per FIFO; power of 2, range 4..256.
  BASE_ADDR, 16'h0000, window match value for addr[31:16].
REQ-002 Clock and reset: one clock `clk`; reset `rstn` is synchronous and active-low.
REQ-003 Ports SHALL be, one per line: name, direction, width, meaning.
  clk  in  1  clock.
  rstn  in  1  synchronous active-low reset.
  cyc  in  1  bus cycle.
  stb  in  1  strobe.
  lock  in  1  ignored.
  we  in  1  write enable.
  cti  in  3  cycle type: 000 classic, 010 incrementing, 111 end of burst.
  sel  in  8  byte selects.
  addr  in  32  byte address.
  wdat  in  64  write data.
  rdat  out  64  read data.
  ack  out  1  transfer done.
  err  out  1  transfer error.
  retry  out  1  not ready; master re-issues the transfer.
  eod  out  1  last read word; RX FIFO drained.
  tx_data  out  64  TX stream data.
  tx_valid  out  1  TX head valid.
  tx_ready  in  1  TX pop.
  rx_data  in  64  RX stream data.
  rx_valid  in  1  RX push request.
  rx_ready  out  1  RX FIFO not full.
  tx_level, rx_level  out  9 each  FIFO occupancy.

Function
REQ-004 A beat SHALL be accepted when cyc & stb are high and the state permits (REQ-005..007); all responses (ack/err/retry/eod/rdat) SHALL be registered, appearing exactly 1 cycle after acceptance.
REQ-005 States SHALL be IDLE, BURST and RESP.
  IDLE: accept; a classic or 111 beat goes to RESP; a 010 beat goes to BURST.
  RESP: drive the response; accept nothing; go to IDLE.
REQ-006 BURST: drive the response and accept the current beat in the same cycle if cyc & stb are high; cti 010 stays in BURST, cti 111 goes to RESP, cyc low goes to IDLE with no acceptance.
REQ-007 Any err or retry response SHALL force the next state to RESP regardless of cti (the burst is terminated).
REQ-008 Exactly one of ack/err/retry SHALL be high in any response cycle; in all other cycles all three SHALL be 0.
REQ-009 Decode: if addr[31:16] != BASE_ADDR, or addr[2:0] != 0, the response SHALL be err.
REQ-010 Write: sel != 8'hFF SHALL give err with no push; TX full SHALL give retry with no push; otherwise push wdat and ack.
REQ-011 Read: RX empty SHALL give retry with rdat = 0; otherwise rdat = RX head, pop, ack.
REQ-012 eod SHALL be high with ack when the popped word leaves rx_level = 0, including when an rx_valid push occurs in the same cycle.
REQ-013 FIFO push and pop in the same cycle SHALL leave the level unchanged; push when full is ignored; pop when empty is ignored.
REQ-014 Pointers SHALL wrap modulo FIFO_DEPTH; the level SHALL range 0..FIFO_DEPTH.
REQ-015 tx_valid = (tx_level != 0); rx_ready = (rx_level != FIFO_DEPTH).
REQ-016 tx_data SHALL be the head word, valid the cycle after the first push (1-cycle write-to-visible latency).

Reset
REQ-017 When rstn is low at a clk edge: state IDLE; FIFOs emptied; ack, err, retry, eod, tx_valid = 0; rdat = 0; levels = 0; rx_ready = 1 from the following cycle.
REQ-018 Reset asserted mid-burst SHALL abort the burst with no response; in-flight data is discarded.

Configuration
REQ-019 Macro DMA_WB_FIFO_SLAVE_EOD_EN controls the eod feature.
  Defined: eod is generated per REQ-012.
  Undefined: eod is tied 0; all other behaviour is identical.

Structure
REQ-020 Package dma_wb_fifo_slave_pkg SHALL hold the CTI constants (CTI_CLASSIC, CTI_INCR, CTI_EOB) and the state enum.
REQ-021 Sub-module dma_wb_fifo_slave_fifo (synchronous FIFO with level output) SHALL be instantiated twice, once for TX and once for RX.

Verification
REQ-022 Classic write, addr 32'h0000_0008, wdat 64'hDEAD_BEEF_0123_4567, sel FF -> ack 1 cycle later; tx_level = 1; tx_data equals the written word.
REQ-023 4-beat incrementing read (cti 010,010,010,111) with RX holding 4 words -> 4 consecutive acks; eod on the 4th ack only; rx_level = 0.
REQ-024 Write burst with TX holding 15 of 16 entries and tx_ready = 0 -> beat 1 ack, beat 2 retry; state RESP then IDLE; tx_level = 16.
REQ-025 Read of addr 32'h0001_0000 -> err; sel 8'h0F write -> err; FIFO levels unchanged in both cases.
REQ-026 rstn low during beat 2 of a burst -> no response the next cycle; all outputs at REQ-017 values.
REQ-027 Simultaneous rx_valid push and bus pop at rx_level = 1 -> ack with eod (macro defined); rx_level = 1 afterwards.
